mips32_pipeline: RTL and testbench
==================================

# mips32_pipeline

Five-stage in-order MIPS32-subset processor core (IF, ID, EX, MEM, WB) with a unified internal word-addressed instruction/data memory and a 32-entry register file. It is the top-level compute block of the design. It runs a program preloaded into its memory from PC 0 until it retires a HLT instruction. Memory and register file are internal arrays that benches initialise and inspect hierarchically.

## Interface
- `MEM_WORDS`, 1024: depth of the unified memory, in 32-bit words.
- `clk`  input  1  rising-edge clock for every stage.
- `rst_n`  input  1  asynchronous active-low reset.
- `halted`  output  1  high once HLT has retired; sticky until reset.
- Hierarchically visible state, names fixed:
  - `Mem[0:MEM_WORDS-1]` (32b).
  - `regfile[0:31]` (32b).
  - `PC` (32b).
  - `HALTED` (drives `halted`).
  - `BRANCH_TAKEN` (1b).

## Operation
- Instruction format:
  - opcode [31:26], rs [25:21], rt [20:16].
  - rd [15:11] for R-type.
  - imm [15:0] for I-type, sign-extended to 32 bits.
- R-type, writes rd = rs op rt: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100 (signed, result 1 or 0), MUL 000101 (low 32 bits).
- I-type, writes rt: ADDI 001010, SUBI 001011, SLTI 001100.
- Memory:
  - LW 001000: rt = Mem[rs+imm].
  - SW 001001: Mem[rs+imm] = rt.
  - Addresses are word indices; use the low log2(MEM_WORDS) bits.
- Branches:
  - BNEQZ 001101 is taken if rs != 0.
  - BEQZ 001110 is taken if rs == 0.
  - Target = PC_of_branch + 1 + imm.
- HLT 111111.
- Any other opcode executes as a NOP: no writes.
- Writes to register 0 are performed (no hardwired zero). Programs do not rely on R0.
- Arithmetic wraps modulo 2^32; no overflow traps.
- PC increments by 1 per fetch (word addressing).

## Timing
- Reset:
  - PC=0, HALTED=0, BRANCH_TAKEN=0.
  - All pipeline registers hold NOP with write enables clear.
  - `Mem` and `regfile` are not reset.
- One instruction is fetched per cycle. A single instruction takes 5 cycles from fetch to WB.
- Register file is write-first: a WB write is visible to the same-cycle ID read.
- Forwarding from EX/MEM and MEM/WB into EX operands. No interlock hardware. Load-use requires one intervening instruction (software-inserted NOP, e.g. `OR R3,R3,R3`).
- Branch resolves in EX:
  - If taken, BRANCH_TAKEN pulses for one cycle and the PC is loaded with the target on the next edge.
  - The two younger instructions (IF/ID, ID/EX) are squashed to NOP.
- HLT:
  - When decoded, fetch stops, the PC freezes and IF/ID is filled with NOP.
  - When HLT reaches WB, HALTED is set.
  - Older instructions complete normally. Nothing younger commits.
- After HALTED, there are no register or memory writes and the PC is stable.
- `rst_n` asserted mid-program aborts all in-flight instructions immediately (no partial commit on the reset edge). Memory contents are retained.

## Structure
- Shared package `mips32_pkg`:
  - opcode localparams.
  - Field-slice constants.
  - NOP encoding: 32'h0c631800.
  - A pipeline-register struct per stage boundary.
- One sub-module `mips32_alu`:
  - Inputs: opcode, A, B/imm.
  - Outputs: result and branch condition.
- Memory, register file, hazard/forward logic and pipeline registers stay in the top.

## Test plan
- Preload regfile[k]=k; ADDI R1,R0,120 / NOP / LW R2,0(R1) / NOP / ADDI R2,R2,45 / NOP / SW R2,1(R1) / HLT (words 28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000); Mem[120]=85.
  - Requires Mem[121]=130, Mem[120]=85 and halted=1 within 20 cycles.
- Back-to-back dependency: ADDI R1,R0,10 ; ADD R2,R1,R1 ; ADD R3,R2,R1 ; HLT.
  - Requires R1=10, R2=20, R3=30 (forwarding).
- Branch loop: R1=3, R2=0; loop ADDI R2,R2,7 ; SUBI R1,R1,1 ; BNEQZ R1,loop ; two trailing ADDI R5,R0,99 ; HLT.
  - Requires R2=21, R1=0 and R5=99 only from post-loop fall-through; squashed slots do not write.
- Halt: HLT followed by SW R2,0(R0) and ADDI R4,R0,1.
  - Requires Mem[0] unchanged, R4 unchanged, halted=1, PC stable.
- Reset mid-run: assert rst_n low at cycle 3 of the first program.
  - Requires PC=0 and halted=0 while reset is low.
  - After release, the program reruns and again yields Mem[121]=130.
- ALU corners: SLT with R1=-1, R2=1 yields 1; MUL 0x10000×0x10000 yields 0; SUB 0-1 yields 32'hffffffff.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared opcodes, instruction field positions and pipeline-register layouts
// for the five-stage MIPS32-subset core.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // OR R3,R3,R3
  localparam logic [31:0] NOP_INSTR = 32'h0c631800;

  typedef struct packed {
    logic        valid;
    logic [31:0] ir;
    logic [31:0] pc;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        reg_we;
    logic        mem_we;
    logic        is_load;
    logic        is_branch;
    logic        is_halt;
    logic        use_imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
  } id_ex_t;

  typedef struct packed {
    logic [4:0]  dest;
    logic        reg_we;
    logic        mem_we;
    logic        is_load;
    logic        is_halt;
    logic [31:0] alu_out;
    logic [31:0] b;
  } ex_mem_t;

  typedef struct packed {
    logic [4:0]  dest;
    logic        reg_we;
    logic        is_halt;
    logic [31:0] wdata;
  } mem_wb_t;

  function automatic if_id_t if_id_nop();
    if_id_t s;
    s       = '0;
    s.ir    = NOP_INSTR;
    return s;
  endfunction

  function automatic id_ex_t id_ex_nop();
    id_ex_t s;
    s      = '0;
    s.op   = OP_OR;
    s.rs   = 5'd3;
    s.rt   = 5'd3;
    s.dest = 5'd3;
    return s;
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Execute-stage arithmetic unit: data result plus the branch condition,
// which is evaluated on operand A only.
module mips32_alu
  import mips32_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        cond
);

  always_comb begin
    result = '0;
    cond   = 1'b0;
    case (op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: result = a + b;
      OP_SUB, OP_SUBI:               result = a - b;
      OP_AND:                        result = a & b;
      OP_OR:                         result = a | b;
      OP_SLT, OP_SLTI:               result = {31'b0, $signed(a) < $signed(b)};
      OP_MUL:                        result = a * b;
      OP_BNEQZ:                      cond   = |a;
      OP_BEQZ:                       cond   = ~|a;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips32_pipeline.sv
// Five-stage in-order MIPS32-subset core with a unified word-addressed memory.
// Forwarding into EX, branches resolved in EX, HLT drains the pipe and stops.
module mips32_pipeline
  import mips32_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] regfile [0:31];
  logic [31:0] PC;
  logic        HALTED;
  logic        BRANCH_TAKEN;

  logic [31:0] pc_d;
  logic        halted_d;
  logic        fetch_stop_q, fetch_stop_d;
  if_id_t      ifid_q, ifid_d;
  id_ex_t      idex_q, idex_d;
  ex_mem_t     exmem_q, exmem_d;
  mem_wb_t     memwb_q, memwb_d;

  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_imm, id_a, id_b;
  logic        halt_dec;
  logic [31:0] ex_a, ex_b, alu_b, alu_result, br_target;
  logic        alu_cond;
  logic [31:0] ld_data;

  assign halted = HALTED;

  // ---------------- ID: decode and write-first register read
  always_comb begin
    id_op  = ifid_q.ir[OP_HI:OP_LO];
    id_rs  = ifid_q.ir[RS_HI:RS_LO];
    id_rt  = ifid_q.ir[RT_HI:RT_LO];
    id_rd  = ifid_q.ir[RD_HI:RD_LO];
    id_imm = {{16{ifid_q.ir[IMM_HI]}}, ifid_q.ir[IMM_HI:IMM_LO]};
    id_a   = (memwb_q.reg_we && memwb_q.dest == id_rs) ? memwb_q.wdata : regfile[id_rs];
    id_b   = (memwb_q.reg_we && memwb_q.dest == id_rt) ? memwb_q.wdata : regfile[id_rt];

    idex_d = id_ex_nop();
    if (ifid_q.valid && !BRANCH_TAKEN) begin
      idex_d.valid = 1'b1;
      idex_d.op    = id_op;
      idex_d.rs    = id_rs;
      idex_d.rt    = id_rt;
      idex_d.a     = id_a;
      idex_d.b     = id_b;
      idex_d.imm   = id_imm;
      idex_d.pc    = ifid_q.pc;
      case (id_op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
          idex_d.reg_we = 1'b1;
          idex_d.dest   = id_rd;
        end
        OP_ADDI, OP_SUBI, OP_SLTI: begin
          idex_d.reg_we  = 1'b1;
          idex_d.dest    = id_rt;
          idex_d.use_imm = 1'b1;
        end
        OP_LW: begin
          idex_d.reg_we  = 1'b1;
          idex_d.dest    = id_rt;
          idex_d.use_imm = 1'b1;
          idex_d.is_load = 1'b1;
        end
        OP_SW: begin
          idex_d.mem_we  = 1'b1;
          idex_d.use_imm = 1'b1;
        end
        OP_BNEQZ, OP_BEQZ: idex_d.is_branch = 1'b1;
        OP_HLT:            idex_d.is_halt   = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- IF: a taken branch outranks a HLT sitting behind it in ID
  always_comb begin
    halt_dec     = ifid_q.valid && !BRANCH_TAKEN && (id_op == OP_HLT);
    fetch_stop_d = fetch_stop_q | halt_dec;
    if (BRANCH_TAKEN) begin
      pc_d   = br_target;
      ifid_d = if_id_nop();
    end else if (fetch_stop_q || halt_dec) begin
      pc_d   = PC;
      ifid_d = if_id_nop();
    end else begin
      pc_d         = PC + 32'd1;
      ifid_d.valid = 1'b1;
      ifid_d.ir    = Mem[PC[AW-1:0]];
      ifid_d.pc    = PC;
    end
  end

  // ---------------- EX: loads are never forwarded from EX/MEM (software spaces them)
  always_comb begin
    ex_a = idex_q.a;
    if (exmem_q.reg_we && !exmem_q.is_load && exmem_q.dest == idex_q.rs)
      ex_a = exmem_q.alu_out;
    else if (memwb_q.reg_we && memwb_q.dest == idex_q.rs)
      ex_a = memwb_q.wdata;

    ex_b = idex_q.b;
    if (exmem_q.reg_we && !exmem_q.is_load && exmem_q.dest == idex_q.rt)
      ex_b = exmem_q.alu_out;
    else if (memwb_q.reg_we && memwb_q.dest == idex_q.rt)
      ex_b = memwb_q.wdata;

    alu_b     = idex_q.use_imm ? idex_q.imm : ex_b;
    br_target = idex_q.pc + 32'd1 + idex_q.imm;
  end

  mips32_alu u_alu (
    .op     (idex_q.op),
    .a      (ex_a),
    .b      (alu_b),
    .result (alu_result),
    .cond   (alu_cond)
  );

  assign BRANCH_TAKEN = idex_q.valid && idex_q.is_branch && alu_cond;

  always_comb begin
    exmem_d.dest    = idex_q.dest;
    exmem_d.reg_we  = idex_q.reg_we;
    exmem_d.mem_we  = idex_q.mem_we;
    exmem_d.is_load = idex_q.is_load;
    exmem_d.is_halt = idex_q.is_halt;
    exmem_d.alu_out = alu_result;
    exmem_d.b       = ex_b;
  end

  // ---------------- MEM / WB
  assign ld_data = Mem[exmem_q.alu_out[AW-1:0]];

  always_comb begin
    memwb_d.dest    = exmem_q.dest;
    memwb_d.reg_we  = exmem_q.reg_we;
    memwb_d.is_halt = exmem_q.is_halt;
    memwb_d.wdata   = exmem_q.is_load ? ld_data : exmem_q.alu_out;
    halted_d        = HALTED | memwb_q.is_halt;
  end

  always_ff @(posedge clk) begin
    if (exmem_q.mem_we && !HALTED)
      Mem[exmem_q.alu_out[AW-1:0]] <= exmem_q.b;
  end

  always_ff @(posedge clk) begin
    if (memwb_q.reg_we && !HALTED)
      regfile[memwb_q.dest] <= memwb_q.wdata;
  end

  // Reset clears every write enable asynchronously, so the array writes above
  // cannot fire on a reset edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      fetch_stop_q <= 1'b0;
      ifid_q       <= if_id_nop();
      idex_q       <= id_ex_nop();
      exmem_q      <= '0;
      memwb_q      <= '0;
    end else begin
      PC           <= pc_d;
      HALTED       <= halted_d;
      fetch_stop_q <= fetch_stop_d;
      ifid_q       <= ifid_d;
      idex_q       <= idex_d;
      exmem_q      <= exmem_d;
      memwb_q      <= memwb_d;
    end
  end

endmodule

// File: tb/tb_mips32_pipeline.sv
// Bench for mips32_pipeline: an instruction-level interpreter predicts final
// state and the halt cycle; directed programs plus random straight-line programs.
module tb_mips32_pipeline;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [31:0] img_mem [0:1023];
  logic [31:0] img_reg [0:31];
  logic [31:0] m_mem [0:1023];
  logic [31:0] m_reg [0:31];

  mips32_pipeline #(.MEM_WORDS(1024)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .halted (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] enc_r(int op, int rs, int rt, int rd);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  // Sequential ISA interpreter: one instruction at a time, no pipeline notion.
  task automatic model_run(output int steps, output int taken, output int hpc);
    logic [31:0] pc, ir, a, b, imm;
    int op, rs, rt, rd;
    pc = 0; steps = 0; taken = 0; hpc = 0;
    while (steps < 5000) begin
      ir  = m_mem[pc[9:0]];
      steps++;
      op  = int'(ir[31:26]);
      rs  = int'(ir[25:21]);
      rt  = int'(ir[20:16]);
      rd  = int'(ir[15:11]);
      a   = m_reg[rs];
      b   = m_reg[rt];
      imm = {{16{ir[15]}}, ir[15:0]};
      if (op == 63) begin
        hpc = int'(pc);
        return;
      end
      case (op)
        0:  m_reg[rd] = a + b;
        1:  m_reg[rd] = a - b;
        2:  m_reg[rd] = a & b;
        3:  m_reg[rd] = a | b;
        4:  m_reg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        5:  m_reg[rd] = a * b;
        8:  m_reg[rt] = m_mem[(a + imm) & 32'h3ff];
        9:  m_mem[(a + imm) & 32'h3ff] = b;
        10: m_reg[rt] = a + imm;
        11: m_reg[rt] = a - imm;
        12: m_reg[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        default: ;
      endcase
      if ((op == 13 && a != 0) || (op == 14 && a == 0)) begin
        pc = pc + 1 + imm;
        taken++;
      end else begin
        pc = pc + 1;
      end
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img_mem[i] = (i >= 512) ? $urandom : 32'h0;
    for (int i = 0; i < 32; i++) img_reg[i] = i;
  endtask

  // Load image, predict, run; halted is checked after every edge, PC once halted,
  // then the whole register file and memory against the model.
  task automatic run_test(input string name, input int abort_at);
    int steps, taken, hpc, e;
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      dut.Mem[i] = img_mem[i];
      m_mem[i]   = img_mem[i];
    end
    for (int i = 0; i < 32; i++) begin
      dut.regfile[i] = img_reg[i];
      m_reg[i]       = img_reg[i];
    end
    model_run(steps, taken, hpc);
    e = steps - 1 + 2 * taken + 5;
    @(negedge clk);
    check({name, " rst PC"}, dut.PC, 32'd0);
    check({name, " rst halted"}, {31'b0, halted}, 32'd0);
    if (abort_at > 0) begin
      rst_n = 1'b1;
      repeat (abort_at) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check({name, " abort PC"}, dut.PC, 32'd0);
      check({name, " abort halted"}, {31'b0, halted}, 32'd0);
      @(negedge clk);
      check({name, " abort PC held"}, dut.PC, 32'd0);
    end
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= e + 3; cyc++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s halted@%0d", name, cyc), {31'b0, halted}, (cyc >= e) ? 32'd1 : 32'd0);
      if (cyc >= e) check($sformatf("%s PC@%0d", name, cyc), dut.PC, hpc + 1);
    end
    for (int i = 0; i < 32; i++)
      check($sformatf("%s R%0d", name, i), dut.regfile[i], m_reg[i]);
    for (int i = 0; i < 1024; i++)
      check($sformatf("%s Mem[%0d]", name, i), dut.Mem[i], m_mem[i]);
    $display("test %s: %0d instrs, %0d taken branches, halt edge %0d", name, steps, taken, e);
  endtask

  task automatic gen_random(input int n);
    int idx, kind, lim;
    clear_img();
    for (int i = 1; i < 8; i++)
      img_reg[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    img_reg[0] = 0;
    idx = 0;
    while (idx < n) begin
      kind = $urandom_range(0, 9);
      if (kind == 6 && idx + 1 >= n) kind = 0;
      case (kind)
        0, 1, 2, 3:
          img_mem[idx] = enc_r($urandom_range(0, 5), $urandom_range(1, 7),
                               $urandom_range(1, 7), $urandom_range(1, 7));
        4, 5:
          img_mem[idx] = enc_i($urandom_range(10, 12), $urandom_range(1, 7),
                               $urandom_range(1, 7), $urandom_range(0, 65535));
        6: begin
          img_mem[idx] = enc_i(8, 0, $urandom_range(1, 7), $urandom_range(512, 1023));
          idx++;
          img_mem[idx] = 32'h0c631800;
        end
        7:
          img_mem[idx] = enc_i(9, 0, $urandom_range(1, 7), $urandom_range(512, 1023));
        8: begin
          lim = (n - idx - 1 < 3) ? n - idx - 1 : 3;
          img_mem[idx] = enc_i($urandom_range(13, 14), $urandom_range(0, 7), 0,
                               $urandom_range(0, lim));
        end
        default:
          img_mem[idx] = {6'b010000, 26'($urandom)};
      endcase
      idx++;
    end
    img_mem[n]     = 32'hfc000000;
    img_mem[n + 1] = enc_i(9, 0, 1, 600);
    img_mem[n + 2] = enc_i(10, 1, 2, 5);
  endtask

  initial begin
    // load / add / store
    clear_img();
    img_mem[0] = 32'h28010078; img_mem[1] = 32'h0c631800;
    img_mem[2] = 32'h20220000; img_mem[3] = 32'h0c631800;
    img_mem[4] = 32'h2842002d; img_mem[5] = 32'h0c631800;
    img_mem[6] = 32'h24220001; img_mem[7] = 32'hfc000000;
    img_mem[120] = 32'd85;
    run_test("ldst", 0);
    check("ldst Mem121", dut.Mem[121], 32'd130);
    check("ldst Mem120", dut.Mem[120], 32'd85);

    run_test("rst_abort", 3);
    check("rst_abort Mem121", dut.Mem[121], 32'd130);

    // back-to-back dependency chain
    clear_img();
    img_mem[0] = 32'h2801000a; img_mem[1] = 32'h00211000;
    img_mem[2] = 32'h00411800; img_mem[3] = 32'hfc000000;
    run_test("fwd", 0);
    check("fwd R1", dut.regfile[1], 32'd10);
    check("fwd R2", dut.regfile[2], 32'd20);
    check("fwd R3", dut.regfile[3], 32'd30);

    // branch loop; fall-through slots accumulate so squash leaks show up
    clear_img();
    img_reg[1] = 3; img_reg[2] = 0; img_reg[5] = 0; img_reg[6] = 0;
    img_mem[0] = 32'h28420007; img_mem[1] = 32'h2c210001;
    img_mem[2] = 32'h3420fffd; img_mem[3] = 32'h28a50063;
    img_mem[4] = 32'h28c60001; img_mem[5] = 32'hfc000000;
    run_test("loop", 0);
    check("loop R2", dut.regfile[2], 32'd21);
    check("loop R1", dut.regfile[1], 32'd0);
    check("loop R5", dut.regfile[5], 32'd99);
    check("loop R6", dut.regfile[6], 32'd1);

    // HLT first, younger SW/ADDI must not commit
    clear_img();
    img_mem[0] = 32'hfc000000; img_mem[1] = 32'h24020000; img_mem[2] = 32'h28040001;
    run_test("halt", 0);
    check("halt Mem0", dut.Mem[0], 32'hfc000000);
    check("halt R4", dut.regfile[4], 32'd4);
    check("halt PC", dut.PC, 32'd1);

    // ALU corners
    clear_img();
    img_reg[1] = 32'hffffffff; img_reg[2] = 1; img_reg[3] = 32'h10000;
    img_reg[4] = 0; img_reg[5] = 1;
    img_mem[0] = 32'h10223000; img_mem[1] = 32'h14633800;
    img_mem[2] = 32'h04854000; img_mem[3] = 32'hfc000000;
    run_test("alu", 0);
    check("alu SLT", dut.regfile[6], 32'd1);
    check("alu MUL", dut.regfile[7], 32'd0);
    check("alu SUB", dut.regfile[8], 32'hffffffff);

    for (int t = 0; t < 6; t++) begin
      gen_random(30);
      run_test($sformatf("rand%0d", t), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
